// File: rtl/fcb_join_pipelined_adder.sv
// Joins two valid/ready operand streams and adds them in a 2-stage carry-split pipeline.
// Optional: define FCB_JOIN_ADDER_COUNT_EN to add the 16-bit sum_cnt transfer counter port.
module fcb_join_pipelined_adder #(
  parameter int w = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_vld,
  output logic         a_rdy,
  input  logic [w-1:0] a_data,
  input  logic         b_vld,
  output logic         b_rdy,
  input  logic [w-1:0] b_data,
  output logic         sum_vld,
  input  logic         sum_rdy,
  output logic [w:0]   sum_data
`ifdef FCB_JOIN_ADDER_COUNT_EN
  ,
  output logic [15:0]  sum_cnt
`endif
);

  localparam int lo = w / 2;
  localparam int hi = w - lo;

  // Handshake: a transfer happens on a rising edge where vld & rdy are both 1.
  // A producer holds vld and data stable until that transfer; rdy never looks at
  // its own side's vld, so there is no combinational loop through the FIFOs.
  logic            s1_vld;
  logic [lo:0]     s1_lo;
  logic [hi-1:0]   s1_ahi;
  logic [hi-1:0]   s1_bhi;
  logic            s2_vld;
  logic            s1_adv;
  logic            s2_adv;
  logic            fire;
  logic [hi:0]     hi_sum;

  assign s2_adv  = ~s2_vld | sum_rdy;
  assign s1_adv  = ~s1_vld | s2_adv;
  assign a_rdy   = b_vld & s1_adv & ~rst;
  assign b_rdy   = a_vld & s1_adv & ~rst;
  assign fire    = a_vld & b_vld & s1_adv & ~rst;
  assign sum_vld = s2_vld;

  // Upper half absorbs the carry out of the lower half in the second stage.
  assign hi_sum = {1'b0, s1_ahi} + {1'b0, s1_bhi} + {{hi{1'b0}}, s1_lo[lo]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_lo    <= '0;
      s1_ahi   <= '0;
      s1_bhi   <= '0;
      s2_vld   <= 1'b0;
      sum_data <= '0;
    end else begin
      if (s1_adv) begin
        s1_vld <= fire;
        if (fire) begin
          s1_lo  <= {1'b0, a_data[lo-1:0]} + {1'b0, b_data[lo-1:0]};
          s1_ahi <= a_data[w-1:lo];
          s1_bhi <= b_data[w-1:lo];
        end
      end
      if (s2_adv) begin
        s2_vld   <= s1_vld;
        sum_data <= {hi_sum, s1_lo[lo-1:0]};
      end
    end
  end

`ifdef FCB_JOIN_ADDER_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_cnt <= 16'd0;
    end else if (s2_vld & sum_rdy) begin
      sum_cnt <= sum_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fcb_join_pipelined_adder.sv
// Directed + random bench for fcb_join_pipelined_adder with an expected-sum queue.
// Exercises the 8-bit block and a 7-bit instance for the odd-width split.
module tb_fcb_join_pipelined_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_vld = 1'b0, b_vld = 1'b0, sum_rdy = 1'b0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_rdy, b_rdy, sum_vld;
  logic [8:0] sum_data;
  logic       a7_vld = 1'b0, b7_vld = 1'b0;
  logic [6:0] a7_data = '0, b7_data = '0;
  logic       a7_rdy, b7_rdy, sum7_vld;
  logic [7:0] sum7_data;
`ifdef FCB_JOIN_ADDER_COUNT_EN
  logic [15:0] sum_cnt, sum7_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int xfer_cnt = 0;
  int push_cnt = 0;
  logic [8:0] exp_q[$];

  fcb_join_pipelined_adder #(.w(8)) dut (
    .clk(clk), .rst(rst),
    .a_vld(a_vld), .a_rdy(a_rdy), .a_data(a_data),
    .b_vld(b_vld), .b_rdy(b_rdy), .b_data(b_data),
    .sum_vld(sum_vld), .sum_rdy(sum_rdy), .sum_data(sum_data)
`ifdef FCB_JOIN_ADDER_COUNT_EN
    , .sum_cnt(sum_cnt)
`endif
  );

  fcb_join_pipelined_adder #(.w(7)) dut7 (
    .clk(clk), .rst(rst),
    .a_vld(a7_vld), .a_rdy(a7_rdy), .a_data(a7_data),
    .b_vld(b7_vld), .b_rdy(b7_rdy), .b_data(b7_data),
    .sum_vld(sum7_vld), .sum_rdy(1'b1), .sum_data(sum7_data)
`ifdef FCB_JOIN_ADDER_COUNT_EN
    , .sum_cnt(sum7_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [7:0] a, input logic bv, input logic [7:0] b);
    a_vld = av; a_data = a; b_vld = bv; b_data = b;
  endtask

  // scoreboard: push on accepted pair, pop on output transfer
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      xfer_cnt = 0;
    end else begin
      if (sum_vld && sum_rdy) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("sb_data", 32'(sum_data), 32'(exp_q.pop_front()));
        xfer_cnt++;
      end
      if (a_vld && a_rdy && b_vld && b_rdy) begin
        exp_q.push_back(9'(a_data) + 9'(b_data));
        push_cnt++;
      end
    end
  end

  initial begin
    // reset state, with both operands offered
    drive(1'b1, 8'h11, 1'b1, 8'h22);
    #1;
    check("rst_sum_vld", 32'(sum_vld), 32'd0);
    check("rst_sum_data", 32'(sum_data), 32'd0);
    check("rst_a_rdy", 32'(a_rdy), 32'd0);
    check("rst_b_rdy", 32'(b_rdy), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    step();
    step();
    rst = 1'b0;
    sum_rdy = 1'b1;
    step();

    // single pair: 0F + 01, visible two cycles later for one cycle
    drive(1'b1, 8'h0F, 1'b1, 8'h01);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    check("single_lat1", 32'(sum_vld), 32'd0);
    step();
    check("single_vld", 32'(sum_vld), 32'd1);
    check("single_data", 32'(sum_data), 32'h010);
    step();
    check("single_drop", 32'(sum_vld), 32'd0);

    // max carry, 8-bit and odd 7-bit split
    drive(1'b1, 8'hFF, 1'b1, 8'hFF);
    a7_vld = 1'b1; a7_data = 7'h7F; b7_vld = 1'b1; b7_data = 7'h01;
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    a7_vld = 1'b0; b7_vld = 1'b0;
    step();
    check("max8_data", 32'(sum_data), 32'h1FE);
    check("w7_vld", 32'(sum7_vld), 32'd1);
    check("w7_data", 32'(sum7_data), 32'h80);
    step();

    // join skew: lone A is never consumed
    drive(1'b1, 8'd5, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("skew_a_rdy", 32'(a_rdy), 32'd0);
      check("skew_no_out", 32'(sum_vld), 32'd0);
      step();
    end
    drive(1'b1, 8'd5, 1'b1, 8'd7);
    #1;
    check("skew_a_rdy_join", 32'(a_rdy), 32'd1);
    check("skew_b_rdy_join", 32'(b_rdy), 32'd1);
    step();
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    step();
    check("skew_vld", 32'(sum_vld), 32'd1);
    check("skew_data", 32'(sum_data), 32'd12);
    step();
    check("skew_single", 32'(sum_vld), 32'd0);

    // backpressure: only two items fit while sum_rdy=0
    sum_rdy = 1'b0;
    drive(1'b1, 8'd1, 1'b1, 8'd1);
    #1;
    check("bp_rdy1", 32'(a_rdy), 32'd1);
    step();
    drive(1'b1, 8'd2, 1'b1, 8'd2);
    #1;
    check("bp_rdy2", 32'(a_rdy), 32'd1);
    step();
    drive(1'b1, 8'd3, 1'b1, 8'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_a_rdy_full", 32'(a_rdy), 32'd0);
      check("bp_b_rdy_full", 32'(b_rdy), 32'd0);
      check("bp_hold_vld", 32'(sum_vld), 32'd1);
      check("bp_hold_data", 32'(sum_data), 32'd2);
      step();
    end
    sum_rdy = 1'b1;
    #1;
    check("bp_rdy_restore", 32'(a_rdy), 32'd1);
    step();
    check("bp_out4", 32'(sum_data), 32'd4);
    check("bp_vld4", 32'(sum_vld), 32'd1);
    drive(1'b1, 8'd4, 1'b1, 8'd4);
    step();
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    check("bp_out6", 32'(sum_data), 32'd6);
    check("bp_vld6", 32'(sum_vld), 32'd1);
    step();
    check("bp_out8", 32'(sum_data), 32'd8);
    check("bp_vld8", 32'(sum_vld), 32'd1);
    step();
    check("bp_empty", 32'(sum_vld), 32'd0);

    // throughput: 20 back-to-back pairs, one result per cycle
    begin
      int n0;
      n0 = xfer_cnt;
      for (int j = 1; j <= 20; j++) begin
        drive(1'b1, 8'(j * 7), 1'b1, 8'(j * 11));
        step();
        if (j >= 2) check("tput_vld", 32'(sum_vld), 32'd1);
      end
      drive(1'b0, 8'd0, 1'b0, 8'd0);
      step();
      step();
      check("tput_count", 32'(xfer_cnt - n0), 32'd20);
    end

    // random: 1000 accepted pairs with random valids and ready
    begin
      int p0;
      int cyc;
      p0 = push_cnt;
      cyc = 0;
      while ((push_cnt - p0) < 1000 && cyc < 20000) begin
        drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        sum_rdy = 1'($urandom_range(0, 1));
        step();
        cyc++;
      end
      drive(1'b0, 8'd0, 1'b0, 8'd0);
      check("rand_accepted", 32'(push_cnt - p0 >= 1000), 32'd1);
      sum_rdy = 1'b1;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
      check("rand_drained", 32'(exp_q.size()), 32'd0);
    end
`ifdef FCB_JOIN_ADDER_COUNT_EN
    check("sum_cnt", 32'(sum_cnt), 32'(xfer_cnt & 32'hFFFF));
`endif

    // reset mid-flight with both stages full
    sum_rdy = 1'b0;
    drive(1'b1, 8'd1, 1'b1, 8'd2);
    step();
    drive(1'b1, 8'd2, 1'b1, 8'd3);
    step();
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    check("mid_full", 32'(sum_vld), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_vld", 32'(sum_vld), 32'd0);
    check("mid_rst_data", 32'(sum_data), 32'd0);
`ifdef FCB_JOIN_ADDER_COUNT_EN
    check("mid_rst_cnt", 32'(sum_cnt), 32'd0);
`endif
    step();
    rst = 1'b0;
    sum_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_no_stale", 32'(sum_vld), 32'd0);
    end
    drive(1'b1, 8'd3, 1'b1, 8'd4);
    step();
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    step();
    check("mid_after_vld", 32'(sum_vld), 32'd1);
    check("mid_after_data", 32'(sum_data), 32'd7);
    step();
    check("mid_final_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
